// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: region decode, FSM states,
// and the region-to-enable mapping.
package mem_pkg;

  typedef enum logic [1:0] {
    REG_ROM  = 2'b00,
    REG_RAM  = 2'b01,
    REG_IO   = 2'b10,
    REG_NONE = 2'b11
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int REGION_LSB = 16;

  // One-hot memory enable for a mapped region; the unmapped region enables nothing.
  function automatic logic [2:0] region_onehot(input region_t r);
    case (r)
      REG_ROM: return 3'b001;
      REG_RAM: return 3'b010;
      REG_IO:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two request ports and the memory-side bus around mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        m_valid;
  logic [1:0]        m_ready;
  logic [ADDR_W-1:0] m_addr0;
  logic [ADDR_W-1:0] m_addr1;
  logic [1:0]        m_we;
  logic [DATA_W-1:0] m_wdata0;
  logic [DATA_W-1:0] m_wdata1;
  logic [1:0]        m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;
  logic [2:0]        mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_sel;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  m_valid, m_addr0, m_addr1, m_we, m_wdata0, m_wdata1, mem_rdata,
    output m_ready, m_rvalid, m_rdata, m_err, mem_en, mem_we, mem_addr, mem_wdata, mem_sel
  );

  // Requester / memory-model side.
  modport master (
    output m_valid, m_addr0, m_addr1, m_we, m_wdata0, m_wdata1, mem_rdata,
    input  m_ready, m_rvalid, m_rdata, m_err, mem_en, mem_we, mem_addr, mem_wdata, mem_sel
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-request round-robin grant; last_grant resets to 1 so M0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    // NOTE: default assigned first so every path drives grant and no latch is inferred.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values together.
    if (!rst_n)      last_grant <= 1'b1;
    else if (update) last_grant <= grant[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory sequencer: arbitrates, decodes the region, drives one memory
// access, waits the read latency and returns a single-cycle response.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic [1:0]        grant;
  logic              take;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_we;
  region_t           req_region;

  region_t           region_q;
  logic              we_q;
  logic              gnt_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        sel_q;

  assign take = (state == ST_IDLE) && (bus.m_valid != 2'b00);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.m_valid),
    .update (take),
    .grant  (grant)
  );

  assign req_addr   = grant[1] ? bus.m_addr1  : bus.m_addr0;
  assign req_wdata  = grant[1] ? bus.m_wdata1 : bus.m_wdata0;
  assign req_we     = grant[1] ? bus.m_we[1]  : bus.m_we[0];
  assign req_region = region_t'(req_addr[REGION_LSB +: 2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (take) state_nxt = (req_region == REG_NONE) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (cnt_q == 3'd0) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Transaction registers: loaded at grant, held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q <= REG_ROM;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= 3'd0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: if (take) begin
          region_q <= req_region;
          we_q     <= req_we;
          gnt_q    <= grant[1];
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          rdata_q  <= '0;
          err_q    <= (req_region == REG_NONE);
          // The read mux never sees 11; an unmapped access leaves it untouched.
          if (req_region != REG_NONE) sel_q <= req_region;
        end
        ST_ACCESS: if (!we_q) cnt_q <= LAT_LOAD;
        ST_WAIT: begin
          if (cnt_q == 3'd0) rdata_q <= bus.mem_rdata;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.m_ready  = (state == ST_IDLE) ? grant : 2'b00;
    bus.mem_en   = (state == ST_ACCESS) ? region_onehot(region_q) : 3'b000;
    bus.mem_we   = (state == ST_ACCESS) && we_q;
    bus.m_rvalid = (state == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  end

  assign bus.m_rdata   = rdata_q;
  assign bus.m_err     = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_sel   = sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: response scoreboard for the RD_LAT=1 build,
// plus a second RD_LAT=3 instance for the long-latency ROM read.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  // Memory model behind the read-data mux: content is a fixed function of address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0001_0004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign bus1.mem_rdata = mem_model(bus1.mem_addr);
  assign bus3.mem_rdata = mem_model(bus3.mem_addr);

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          exp_last = 1;
  logic [31:0] req_addr[2];
  logic        req_we[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_m_ready"},   bus1.m_ready,   0);
    check({pfx, "_m_rvalid"},  bus1.m_rvalid,  0);
    check({pfx, "_m_rdata"},   bus1.m_rdata,   0);
    check({pfx, "_m_err"},     bus1.m_err,     0);
    check({pfx, "_mem_en"},    bus1.mem_en,    0);
    check({pfx, "_mem_we"},    bus1.mem_we,    0);
    check({pfx, "_mem_addr"},  bus1.mem_addr,  0);
    check({pfx, "_mem_wdata"}, bus1.mem_wdata, 0);
    check({pfx, "_mem_sel"},   bus1.mem_sel,   0);
  endtask

  task automatic drive(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      bus1.m_addr0  = addr;
      bus1.m_wdata0 = wd;
    end else begin
      bus1.m_addr1  = addr;
      bus1.m_wdata1 = wd;
    end
    bus1.m_we[m]    = we;
    bus1.m_valid[m] = 1'b1;
    req_addr[m]     = addr;
    req_we[m]       = we;
  endtask

  // Waits for any grant, checks it went to master m, and records the expected response.
  task automatic wait_grant(input int m, output int cyc);
    bit          ok;
    logic [1:0]  oh;
    resp_t       e;
    logic [1:0]  rgn;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (bus1.m_ready !== 2'b00) ok = 1'b1;
    end
    check("grant_seen", ok, 1);
    oh = 2'b01 << m;
    check("grant_master", bus1.m_ready, oh);
    exp_last = m;
    rgn      = req_addr[m][17:16];
    e.m      = m;
    e.err    = (rgn == 2'b11);
    e.data   = (req_we[m] || rgn == 2'b11) ? 32'h0 : mem_model(req_addr[m]);
    sb.push_back(e);
  endtask

  // Counts cycles until master m sees its response; expects it on cycle exp_k.
  task automatic wait_resp(input int m, input int exp_k);
    int k;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (bus1.m_rvalid[m]) break;
    end
    check("resp_latency", k, exp_k);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus1.m_rvalid !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", bus1.m_rvalid, 0);
      end else begin
        resp_t      e;
        logic [1:0] oh;
        e  = sb.pop_front();
        oh = 2'b01 << e.m;
        check("sb_rvalid", bus1.m_rvalid, oh);
        check("sb_rdata", bus1.m_rdata, e.data);
        check("sb_err", bus1.m_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    logic [1:0] oh;
    int exp_m;
    bit ok;

    bus1.m_valid = 2'b00; bus1.m_we = 2'b00;
    bus1.m_addr0 = '0; bus1.m_addr1 = '0; bus1.m_wdata0 = '0; bus1.m_wdata1 = '0;
    bus3.m_valid = 2'b00; bus3.m_we = 2'b00;
    bus3.m_addr0 = '0; bus3.m_addr1 = '0; bus3.m_wdata0 = '0; bus3.m_wdata1 = '0;

    #12;
    check_reset_outputs("rst");
    check("rst3_mem_sel", bus3.mem_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single CPU read from RAM.
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0001_0004, 32'h0);
    wait_grant(0, cyc);
    check("rd_idle_mem_en", bus1.mem_en, 0);
    @(posedge clk); #1;
    bus1.m_valid[0] = 1'b0;
    @(negedge clk);
    check("rd_mem_en", bus1.mem_en, 3'b010);
    check("rd_mem_sel", bus1.mem_sel, 2'b01);
    check("rd_mem_we", bus1.mem_we, 0);
    check("rd_mem_addr", bus1.mem_addr, 32'h0001_0004);
    wait_resp(0, 2);
    check("rd_rdata", bus1.m_rdata, 32'hDEAD_BEEF);
    check("rd_err", bus1.m_err, 0);

    // Write from M1 to the I/O region.
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h0002_0000, 32'h0000_005A);
    wait_grant(1, cyc);
    @(posedge clk); #1;
    bus1.m_valid[1] = 1'b0; bus1.m_we[1] = 1'b0;
    @(negedge clk);
    check("wr_mem_en", bus1.mem_en, 3'b100);
    check("wr_mem_we", bus1.mem_we, 1);
    check("wr_mem_wdata", bus1.mem_wdata, 32'h5A);
    check("wr_mem_sel", bus1.mem_sel, 2'b10);
    wait_resp(1, 1);
    check("wr_resp_mem_en", bus1.mem_en, 0);
    check("wr_resp_mem_we", bus1.mem_we, 0);

    // Contention: both masters hold valid across four transactions.
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0001_0100, 32'h0);
    drive(1, 1'b0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_m = (exp_last == 1) ? 0 : 1;
      check("cont_order", exp_m, i % 2);
      wait_grant(exp_m, cyc);
      if (i > 0) check("cont_spacing", cyc, 4);
      @(posedge clk); #1;
      if (exp_m == 0) drive(0, 1'b0, 32'h0001_0100 + 32'(16 * (i + 1)), 32'h0);
      else            drive(1, 1'b0, 32'h0002_0200 + 32'(16 * (i + 1)), 32'h0);
    end
    bus1.m_valid = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1'b1;
    end
    check("cont_drain", sb.size(), 0);

    // Unmapped region: no memory access, immediate error response.
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0003_0000, 32'h0);
    wait_grant(0, cyc);
    check("unm_idle_mem_en", bus1.mem_en, 0);
    @(posedge clk); #1;
    bus1.m_valid[0] = 1'b0;
    wait_resp(0, 1);
    check("unm_mem_en", bus1.mem_en, 0);
    check("unm_err", bus1.m_err, 1);
    check("unm_rdata", bus1.m_rdata, 0);

    // Reset during WAIT aborts the read.
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0001_0040, 32'h0);
    wait_grant(0, cyc);
    @(posedge clk); #1;
    bus1.m_valid[0] = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    check("mid_wait_rvalid", bus1.m_rvalid, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    exp_last = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus1.m_rvalid !== 2'b00) seen++;
    end
    check("no_resp_after_reset", seen, 0);

    @(posedge clk); #1;
    drive(1, 1'b0, 32'h0000_0044, 32'h0);
    wait_grant(1, cyc);
    @(posedge clk); #1;
    bus1.m_valid[1] = 1'b0;
    @(negedge clk);
    check("post_rst_mem_en", bus1.mem_en, 3'b001);
    wait_resp(1, 2);
    check("post_rst_rdata", bus1.m_rdata, mem_model(32'h0000_0044));

    // RD_LAT=3 instance: ROM read, selector held through every WAIT cycle.
    @(posedge clk); #1;
    bus3.m_addr0 = 32'h0000_0010; bus3.m_we = 2'b00; bus3.m_valid = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus3.m_ready !== 2'b00) ok = 1'b1;
    end
    check("lat3_grant", bus3.m_ready, 2'b01);
    @(posedge clk); #1;
    bus3.m_valid = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("lat3_sel", bus3.mem_sel, 2'b00);
      if (k == 1) check("lat3_mem_en", bus3.mem_en, 3'b001);
      if (k < 5) begin
        check("lat3_no_rvalid", bus3.m_rvalid, 0);
      end else begin
        oh = 2'b01;
        check("lat3_rvalid", bus3.m_rvalid, oh);
        check("lat3_rdata", bus3.m_rdata, mem_model(32'h0000_0010));
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-master, round-robin arbiter and sequencer for the three-region memory subsystem (instruction ROM, data RAM, I/O region).
- Accepts one request at a time from the CPU port (M0) or the secondary port (M1, e.g. display scanner).
- Decodes the region, drives the selected memory's enable, and generates the 2-bit memory selector for the read-data multiplexer.
- Waits the fixed read latency, then returns the multiplexed read data to the granted master with a one-cycle response pulse.

## Interface

Parameters:
- ADDR_W, 32, address width; region decode uses addr[17:16]
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles, 1..7

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_valid  in  2  request valid per master ([0]=CPU, [1]=secondary)
- m_ready  out  2  request accepted, one-hot or zero
- m_addr0, m_addr1  in  ADDR_W  request address per master
- m_we  in  2  write enable per master
- m_wdata0, m_wdata1  in  DATA_W  write data per master
- m_rvalid  out  2  response pulse per master
- m_rdata  out  DATA_W  response data, shared, qualified by m_rvalid
- m_err  out  1  unmapped-region flag, qualified by m_rvalid
- mem_en  out  3  per-region access enable, one-hot or zero
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_sel  out  2  selector to the read-data mux (00/01/10)
- mem_rdata  in  DATA_W  mux output

## Operation

- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - If any m_valid is set, grant one master and assert its m_ready combinationally in the same cycle.
  - Latch addr, we and wdata; decode region = addr[17:16].
  - Regions 00, 01, 10 go to ACCESS; region 11 goes to RESP with err=1 and rdata=0.
- **ACCESS**
  - One cycle: mem_en[region]=1, mem_we=latched we, mem_addr and mem_wdata driven.
  - Writes go to RESP. Reads load wait counter = RD_LAT-1 and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, capture mem_rdata into the response register and go to RESP.
- **RESP**
  - One cycle: m_rvalid[granted]=1 with m_rdata and m_err.
  - Writes return rdata=0, err=0. Return to IDLE.
- **Round-robin arbitration**
  - last_grant register, reset value 1, so M0 wins the first contention.
  - Both valid: grant ~last_grant. Single valid: grant it.
  - last_grant is updated on every grant.
- **Registered outputs**
  - mem_sel is registered at grant and held constant from ACCESS through RESP.
  - mem_sel keeps its value in IDLE; no glitching between transactions.
- m_ready is never asserted outside IDLE, so masters must hold valid and payload until ready.
- **Reset values:** state=IDLE, m_ready=0, m_rvalid=0, m_rdata=0, m_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_sel=00, last_grant=1.
- Reset asserted mid-transaction aborts it immediately; no response is issued afterwards.

## Timing

- Request accepted at cycle T (valid & ready):
  - Read, mapped region: m_rvalid at T+2+RD_LAT (T+3 at default).
  - Write, mapped region: m_rvalid at T+2.
  - Unmapped region, read or write: m_rvalid at T+1; mem_en stays 0 throughout.
- Throughput: next grant no earlier than the cycle after RESP. Back-to-back reads at RD_LAT=1 take 4 cycles each.
- A master whose valid stays high while its response is issued may be re-granted in the following IDLE cycle, subject to round-robin.

## Structure

- Shared package mem_pkg holds:
  - region enum: REG_ROM=2'b00, REG_RAM=2'b01, REG_IO=2'b10, REG_NONE=2'b11
  - FSM state enum
  - REGION_LSB=16 constant
- One sub-module, rr_arbiter2: 2-request round-robin grant with last_grant state and an update strobe.

## Test plan

- **Single CPU read:** M0 valid, addr=0x0001_0004, RAM returns 0xDEADBEEF.
  - mem_en=010 and mem_sel=01 in ACCESS.
  - m_rvalid[0] at T+3 with m_rdata=0xDEADBEEF, m_err=0.
- **Write:** M1 valid, we=1, addr=0x0002_0000, wdata=0x5A.
  - mem_en=100, mem_we=1, mem_wdata=0x5A for exactly one cycle.
  - m_rvalid[1] at T+2.
- **Contention:** both masters valid continuously for 4 transactions.
  - Grant order M0, M1, M0, M1.
  - Each response goes only to its own master.
- **Unmapped address:** addr=0x0003_0000.
  - No mem_en pulse.
  - m_rvalid at T+1 with m_err=1, m_rdata=0.
- **RD_LAT=3 build:** ROM read.
  - Response at T+5; mem_sel stays 00 across all WAIT cycles.
- **Reset mid-op:** assert rst_n=0 during WAIT.
  - All outputs go to reset values asynchronously.
  - No m_rvalid after release; the next request is served normally.
